column_reducer: RTL and testbench
=================================

Name: column_reducer

Overview:
- Parametrised successor to the single-mode column summer.
- Reduces a packed column of up to SIZE IEEE-754 cells to one cell. Runtime length and mode are selectable: SUM, ABS_SUM (sum of magnitudes) or MAX (float maximum).
- SUM and ABS_SUM drive the existing stb/ack floating-point `adder`. MAX uses a local single-cycle comparator.
- Sits between the matrix buffer and the coprocessor result path, with ready/ack handshakes on both sides.

Parameters:
- SIZE, 4, maximum number of cells per column.
- CELL_WIDTH, 32, cell width (IEEE-754 single; sign at MSB).
- WIDTH, CELL_WIDTH*SIZE, packed column width.
- LEN_W, $clog2(SIZE+1), width of the length field.

Ports:
- in_clk  in  1  clock; all logic on posedge.
- in_reset  in  1  reset, synchronous, active-high.
- in_col  in  WIDTH  packed column; cell k at in_col[k*CELL_WIDTH +: CELL_WIDTH], cell 0 at LSB.
- in_len  in  LEN_W  number of valid cells.
- in_mode  in  2  0=SUM, 1=ABS_SUM, 2=MAX, 3=reserved (treated as SUM).
- in_ready  in  1  request valid.
- in_ack  out  1  one-cycle pulse: request captured.
- out_ready  out  1  result valid.
- out_ack  in  1  consumer has taken the result.
- out_cell  out  CELL_WIDTH  reduction result.
- out_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (in_reset=1 at posedge, any state, including mid-add):
  - state to IDLE; out_cell=0; out_ready=0; in_ack=0; out_busy=0; counter=0.
  - adder rst=1; a_stb, b_stb and z_ack all 0.
  - Any in-flight adder operation is discarded.
- States: IDLE, LOAD, ISSUE, WAIT, DONE (encoding in package).
- IDLE:
  - Adder rst held 1.
  - On in_ready=1: register in_col, mode and len_eff = min(in_len, SIZE).
  - Pulse in_ack next cycle; go to LOAD.
- LOAD (1 cycle):
  - len_eff=0: acc=0, go to DONE.
  - Otherwise acc=cell0 (sign cleared if ABS_SUM) and counter=1.
  - Then: len_eff=1 goes to DONE; MAX goes to ISSUE-as-compare; else ISSUE.
- ISSUE:
  - Adder modes: drive input_a=cell[counter] (sign cleared if ABS_SUM), input_b=acc, a_stb=b_stb=1; go to WAIT.
  - MAX: acc = fp_max(acc, cell[counter]); counter++. When counter reaches len_eff go to DONE, else stay. Exactly 1 cycle per cell.
- WAIT:
  - Keep strobes asserted with stable operands until output_z_stb=1.
  - Then acc=output_z, drop strobes, z_ack=1 for exactly one cycle, counter++.
  - counter==len_eff goes to DONE, else ISSUE.
  - No timeout.
- DONE:
  - out_cell=acc, out_ready=1, both held stable until out_ack=1.
  - On out_ack: IDLE next cycle, out_ready=0, adder rst=1.
  - out_cell holds its value in IDLE until the next LOAD.
  - in_ready during DONE (including together with out_ack) is ignored; a request is captured no earlier than the first IDLE cycle.
- Latency:
  - len_eff≤1: 3 cycles from capture to out_ready.
  - MAX: len_eff+2 cycles.
  - Adder modes: 2 + (len_eff-1)·(2 + adder latency).
- MAX ordering:
  - Opposite signs: the positive one wins; +0 > −0.
  - Both positive: larger magnitude bits win.
  - Both negative: smaller magnitude bits win.
  - Ties keep acc. NaN is compared by bit pattern only.
- Arithmetic: no rounding or exception handling beyond what `adder` provides.
- in_col, in_len and in_mode are don't-care except in the capture cycle.

Decomposition:
- Package column_pkg:
  - mode constants MODE_SUM=0, MODE_ABS=1, MODE_MAX=2;
  - state encodings;
  - function abs_cell (clear MSB).
- One combinational sub-module fp_max_cmp (inputs a, b; output a_gt_b), used for MAX.
- Existing `adder` instantiated unchanged.

Test Plan:
- SUM, len=4, cells {1.0,2.0,3.0,4.0} = 3F800000,40000000,40400000,40800000 → out_cell=41200000 (10.0); out_ready held until out_ack; in_ack pulses once.
- ABS_SUM, len=4, {3F800000, C0000000, 40400000, C0800000} → 41200000. Same data in SUM → C0000000 (−2.0).
- MAX, same data → 40400000 (3.0) in exactly 6 cycles after capture. {+0, −0} with len=2 → 00000000.
- len=0 → out_cell=00000000; len=1 → cell0 unchanged (abs in ABS_SUM mode). Adder strobes never asserted in either case. len=7 → clamped to 4.
- in_reset pulsed while in WAIT → next cycle IDLE, out_ready=0, out_busy=0, adder rst=1. A new SUM request then completes correctly.
- out_ack and in_ready high together in DONE → request not captured that cycle; captured in following IDLE with in_ack pulse. Back-to-back results are correct.

Source files
------------

// File: rtl/column_pkg.sv
// Shared definitions for the column reducer: reduction modes, FSM states and cell helpers.
package column_pkg;

    localparam int unsigned CELL_W = 32;

    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_ABS = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StDone
    } state_e;

    function automatic logic [CELL_W-1:0] abs_cell(input logic [CELL_W-1:0] c);
        return {1'b0, c[CELL_W-2:0]};
    endfunction

endpackage

// File: rtl/adder.sv
// Single-precision floating-point adder with stb/ack handshakes; truncates, flushes denormals.
module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [1:0] {AddGet, AddCalc, AddPut} add_state_e;

    add_state_e  st_q, st_d;
    logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  d;
        logic [27:0] mx, my, r;
        logic [9:0]  e;
        logic [4:0]  lz;
        logic        found;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (x[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (y[30:23] == 8'd0) return x;
        d  = x[30:23] - y[30:23];
        // Hidden bit at 26, three guard bits below the fraction, carry room at 27.
        mx = {1'b0, 1'b1, x[22:0], 3'b000};
        my = {1'b0, 1'b1, y[22:0], 3'b000};
        my = (d > 8'd26) ? 28'd0 : (my >> d);
        e  = {2'b00, x[30:23]};
        if (x[31] == y[31]) begin
            r = mx + my;
            if (r[27]) begin
                r = r >> 1;
                e = e + 10'd1;
            end
        end else begin
            r = mx - my;
            if (r == 28'd0) return 32'd0;
            lz    = 5'd0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (r[i]) found = 1'b1;
                    else      lz = lz + 5'd1;
                end
            end
            r = r << lz;
            if ({5'd0, lz} >= e) return {x[31], 31'd0};
            e = e - {5'd0, lz};
        end
        if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], e[7:0], r[25:3]};
    endfunction

    always_comb begin
        st_d = st_q;
        a_d  = a_q;
        b_d  = b_q;
        z_d  = z_q;
        unique case (st_q)
            AddGet: begin
                if (input_a_stb && input_b_stb) begin
                    a_d  = input_a;
                    b_d  = input_b;
                    st_d = AddCalc;
                end
            end
            AddCalc: begin
                z_d  = fp_add(a_q, b_q);
                st_d = AddPut;
            end
            AddPut: begin
                if (output_z_ack) st_d = AddGet;
            end
            default: st_d = AddGet;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= AddGet;
            a_q  <= '0;
            b_q  <= '0;
            z_q  <= '0;
        end else begin
            st_q <= st_d;
            a_q  <= a_d;
            b_q  <= b_d;
            z_q  <= z_d;
        end
    end

    assign output_z     = z_q;
    assign output_z_stb = (st_q == AddPut);

endmodule

// File: rtl/fp_max_cmp.sv
// Combinational IEEE-754 ordering: a_gt_b is set only when a is strictly greater than b.
module fp_max_cmp #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b
);

    always_comb begin
        a_gt_b = 1'b0;
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            // Opposite signs: whichever is positive wins, so +0 beats -0.
            a_gt_b = b[WIDTH-1];
        end else if (!a[WIDTH-1]) begin
            a_gt_b = a[WIDTH-2:0] > b[WIDTH-2:0];
        end else begin
            a_gt_b = a[WIDTH-2:0] < b[WIDTH-2:0];
        end
    end

endmodule

// File: rtl/column_reducer.sv
// Reduces a packed column of float cells to one cell by SUM, ABS_SUM or MAX.
module column_reducer
    import column_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int CELL_WIDTH = 32,
    parameter int WIDTH      = CELL_WIDTH * SIZE,
    parameter int LEN_W      = $clog2(SIZE + 1)
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic [WIDTH-1:0]      in_col,
    input  logic [LEN_W-1:0]      in_len,
    input  logic [1:0]            in_mode,
    input  logic                  in_ready,
    output logic                  in_ack,
    output logic                  out_ready,
    input  logic                  out_ack,
    output logic [CELL_WIDTH-1:0] out_cell,
    output logic                  out_busy
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      col_q, col_d;
    logic [1:0]            mode_q, mode_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [CELL_WIDTH-1:0] acc_q, acc_d;
    logic                  in_ack_q, in_ack_d;
    logic                  stb_q, stb_d;
    logic                  z_ack_q, z_ack_d;

    logic [CELL_WIDTH-1:0] cells [SIZE];
    logic [CELL_WIDTH-1:0] cur_cell, opnd_a;
    logic [IDX_W-1:0]      idx;
    logic                  cell_gt_acc;
    logic                  adder_rst;
    logic [31:0]           sum_z;
    logic                  sum_z_stb;

    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            cells[k] = col_q[k*CELL_WIDTH +: CELL_WIDTH];
        end
    end

    assign idx      = cnt_q[IDX_W-1:0];
    assign cur_cell = cells[idx];
    assign opnd_a   = (mode_q == MODE_ABS) ? abs_cell(cur_cell) : cur_cell;

    fp_max_cmp #(
        .WIDTH (CELL_WIDTH)
    ) u_max_cmp (
        .a      (cur_cell),
        .b      (acc_q),
        .a_gt_b (cell_gt_acc)
    );

    // The adder is parked in reset whenever no reduction is in flight.
    assign adder_rst = in_reset || (state_q == StIdle);

    adder u_adder (
        .clk          (in_clk),
        .rst          (adder_rst),
        .input_a      (opnd_a),
        .input_a_stb  (stb_q),
        .input_b      (acc_q),
        .input_b_stb  (stb_q),
        .output_z     (sum_z),
        .output_z_stb (sum_z_stb),
        .output_z_ack (z_ack_q)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        mode_d   = mode_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        in_ack_d = 1'b0;
        stb_d    = stb_q;
        z_ack_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_ready) begin
                    col_d    = in_col;
                    mode_d   = in_mode;
                    len_d    = (in_len > LEN_W'(SIZE)) ? LEN_W'(SIZE) : in_len;
                    cnt_d    = '0;
                    in_ack_d = 1'b1;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (len_q == '0) begin
                    acc_d   = '0;
                    state_d = StDone;
                end else begin
                    acc_d   = opnd_a;
                    cnt_d   = LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (mode_q == MODE_MAX) begin
                    acc_d   = cell_gt_acc ? cur_cell : acc_q;
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_d == len_q) ? StDone : StIssue;
                end else begin
                    stb_d   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sum_z_stb) begin
                    acc_d   = sum_z;
                    stb_d   = 1'b0;
                    z_ack_d = 1'b1;
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_d == len_q) ? StDone : StIssue;
                end
            end
            StDone: begin
                if (out_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q  <= StIdle;
            col_q    <= '0;
            mode_q   <= MODE_SUM;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            in_ack_q <= 1'b0;
            stb_q    <= 1'b0;
            z_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            in_ack_q <= in_ack_d;
            stb_q    <= stb_d;
            z_ack_q  <= z_ack_d;
        end
    end

    assign in_ack    = in_ack_q;
    assign out_ready = (state_q == StDone);
    assign out_cell  = acc_q;
    assign out_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_column_reducer.sv
// Directed bench for column_reducer: modes, length edge cases, reset mid-add, back-to-back requests.
module tb_column_reducer;
    import column_pkg::*;

    localparam int SIZE = 4;
    localparam int CW   = 32;
    localparam int W    = CW * SIZE;
    localparam int LW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  col;
    logic [LW-1:0] len;
    logic [1:0]    mode;
    logic          in_ready, in_ack, out_ready, out_ack, busy;
    logic [CW-1:0] out_cell;

    int n_checks = 0;
    int n_fail   = 0;

    column_reducer #(
        .SIZE       (SIZE),
        .CELL_WIDTH (CW)
    ) dut (
        .in_clk    (clk),
        .in_reset  (rst),
        .in_col    (col),
        .in_len    (len),
        .in_mode   (mode),
        .in_ready  (in_ready),
        .in_ack    (in_ack),
        .out_ready (out_ready),
        .out_ack   (out_ack),
        .out_cell  (out_cell),
        .out_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] col4(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic start_req(input logic [W-1:0] c, input logic [LW-1:0] l, input logic [1:0] m);
        @(negedge clk);
        col      = c;
        len      = l;
        mode     = m;
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        // Inputs are don't-care after capture; scramble them.
        col      = {W{1'b1}};
        len      = '0;
        mode     = 2'd3;
    endtask

    // lat counts the capture edge through the first edge that samples out_ready high.
    task automatic wait_done(output logic [31:0] res, output int lat, output int acks,
                             output bit strobed);
        lat     = 1;
        acks    = 0;
        strobed = 1'b0;
        res     = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ack) acks++;
            if (dut.stb_q) strobed = 1'b1;
            if (out_ready) begin
                res = out_cell;
                lat++;
                return;
            end
            @(posedge clk);
            lat++;
        end
        check_eq("done_timeout", 32'(out_ready), 32'd1);
    endtask

    task automatic finish_req(input string tag, input logic [31:0] res);
        repeat (3) @(negedge clk);
        check_eq({tag, "_hold_rdy"}, 32'(out_ready), 32'd1);
        check_eq({tag, "_hold_cell"}, out_cell, res);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check_eq({tag, "_rdy_drop"}, 32'(out_ready), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idle_cell"}, out_cell, res);
    endtask

    task automatic run(input string tag, input logic [W-1:0] c, input logic [LW-1:0] l,
                       input logic [1:0] m, input logic [31:0] exp, input int exp_lat,
                       input bit exp_strobe);
        logic [31:0] res;
        int          lat, acks;
        bit          strobed;
        start_req(c, l, m);
        wait_done(res, lat, acks, strobed);
        check_eq({tag, "_result"}, res, exp);
        check_eq({tag, "_in_ack_pulses"}, 32'(acks), 32'd1);
        check_eq({tag, "_adder_used"}, 32'(strobed), 32'(exp_strobe));
        if (exp_lat >= 0) check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        finish_req(tag, exp);
    endtask

    initial begin
        logic [W-1:0] d_pos, d_mix, d_neg0, d_zero;
        logic [31:0]  res;
        int           lat, acks;
        bit           strobed, reached;

        d_pos  = col4(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        d_mix  = col4(32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'hC080_0000);
        d_neg0 = col4(32'hC000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000);
        d_zero = col4(32'h0000_0000, 32'h8000_0000, 32'h4040_0000, 32'h4080_0000);

        rst      = 1'b1;
        in_ready = 1'b0;
        out_ack  = 1'b0;
        col      = '0;
        len      = '0;
        mode     = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_cell", out_cell, 32'h0);
        check_eq("rst_out_ready", 32'(out_ready), 32'd0);
        check_eq("rst_in_ack", 32'(in_ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_adder_rst", 32'(dut.adder_rst), 32'd1);
        rst = 1'b0;

        run("sum4", d_pos, 3'd4, MODE_SUM, 32'h4120_0000, -1, 1'b1);
        run("abs4", d_mix, 3'd4, MODE_ABS, 32'h4120_0000, -1, 1'b1);
        run("sum_mix", d_mix, 3'd4, MODE_SUM, 32'hC000_0000, -1, 1'b1);
        run("max4", d_mix, 3'd4, MODE_MAX, 32'h4040_0000, 6, 1'b0);
        run("max_zeros", d_zero, 3'd2, MODE_MAX, 32'h0000_0000, 4, 1'b0);
        run("len0", d_pos, 3'd0, MODE_SUM, 32'h0000_0000, 3, 1'b0);
        run("len1_abs", d_neg0, 3'd1, MODE_ABS, 32'h4000_0000, 3, 1'b0);
        run("len1_sum", d_neg0, 3'd1, MODE_SUM, 32'hC000_0000, 3, 1'b0);
        run("len7_clamp", d_pos, 3'd7, MODE_SUM, 32'h4120_0000, -1, 1'b1);
        run("mode3_sum", d_mix, 3'd3, 2'd3, 32'h4000_0000, -1, 1'b1);

        // Reset while the adder is busy.
        start_req(d_pos, 3'd4, MODE_SUM);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk);
            if (dut.state_q == StWait) reached = 1'b1;
        end
        check_eq("reach_wait", 32'(reached), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_ready", 32'(out_ready), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_adder_rst", 32'(dut.adder_rst), 32'd1);
        check_eq("midrst_cell", out_cell, 32'h0);
        check_eq("midrst_stb", 32'(dut.stb_q), 32'd0);
        run("after_rst", d_pos, 3'd4, MODE_SUM, 32'h4120_0000, -1, 1'b1);

        // out_ack and in_ready together in DONE: the request waits for IDLE.
        start_req(d_pos, 3'd4, MODE_SUM);
        wait_done(res, lat, acks, strobed);
        check_eq("b2b_first", res, 32'h4120_0000);
        @(negedge clk);
        out_ack  = 1'b1;
        in_ready = 1'b1;
        col      = d_mix;
        len      = 3'd4;
        mode     = MODE_MAX;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check_eq("b2b_no_capture_ack", 32'(in_ack), 32'd0);
        check_eq("b2b_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        check_eq("b2b_capture_ack", 32'(in_ack), 32'd1);
        wait_done(res, lat, acks, strobed);
        check_eq("b2b_second", res, 32'h4040_0000);
        finish_req("b2b", 32'h4040_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
